// File: rtl/core_multicycle_ctrl_if.sv
// rtl/core_multicycle_ctrl_if.sv - decode/execute-unit/write-back bundle of the multicycle scheduler
interface core_multicycle_ctrl_if #(
  parameter int CNT_WIDTH = 8
);
  logic                 mc_req_i;
  logic [1:0]           mc_unit_i;
  logic [4:0]           mc_rd_i;
  logic                 flush_i;
  logic [3:0]           unit_start_o;
  logic [3:0]           unit_done_i;
  logic                 stall_general_o;
  logic                 wb_valid_o;
  logic [1:0]           wb_unit_o;
  logic [4:0]           wb_rd_o;
  logic [CNT_WIDTH-1:0] busy_cnt_o;
  logic                 timeout_err_o;

  // Scheduler side
  modport slave (
    input  mc_req_i, mc_unit_i, mc_rd_i, flush_i, unit_done_i,
    output unit_start_o, stall_general_o, wb_valid_o, wb_unit_o, wb_rd_o,
           busy_cnt_o, timeout_err_o
  );

  // Decode / execute-unit / write-back side
  modport master (
    output mc_req_i, mc_unit_i, mc_rd_i, flush_i, unit_done_i,
    input  unit_start_o, stall_general_o, wb_valid_o, wb_unit_o, wb_rd_o,
           busy_cnt_o, timeout_err_o
  );
endinterface

// File: rtl/core_multicycle_ctrl.sv
// rtl/core_multicycle_ctrl.sv - single-in-flight multicycle execute scheduler; optional watchdog via MC_TIMEOUT_EN
module core_multicycle_ctrl #(
  parameter int                   CNT_WIDTH = 8,
  parameter logic [CNT_WIDTH-1:0] TIMEOUT   = CNT_WIDTH'(64)
) (
  input logic                   clk,
  input logic                   rst_n,
  core_multicycle_ctrl_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_WB} state_t;

  state_t               r_state;
  state_t               w_nxt;
  logic [1:0]           r_unit;
  logic [4:0]           r_rd;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [1:0]           r_wb_unit;
  logic [4:0]           r_wb_rd;
  logic                 w_accept;
  logic                 w_done;
  logic                 w_timeout;
  logic                 w_stall;
  logic                 w_wb_valid;
  logic [3:0]           w_start;

  // Flush only kills a request that has not yet been issued
  assign w_accept = (r_state == S_IDLE) && bus.mc_req_i && !bus.flush_i;
  // Only the done pulse of the unit we started counts
  assign w_done   = bus.unit_done_i[r_unit];

`ifdef MC_TIMEOUT_EN
  localparam logic [CNT_WIDTH-1:0] LP_TO_LAST = TIMEOUT - 1'b1;
  logic r_err;

  // Watchdog fires only when the matching done is absent this cycle
  assign w_timeout = (r_state == S_BUSY) && !w_done && (r_cnt >= LP_TO_LAST);

  // Sticky error flag, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_err <= 1'b0;
    else if (w_timeout) r_err <= 1'b1;
  end

  assign bus.timeout_err_o = r_err;
`else
  wire w_unused_timeout = ^TIMEOUT;

  assign w_timeout         = 1'b0;
  assign bus.timeout_err_o = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_nxt;
  end

  // Next-state and combinational handshake outputs
  always_comb begin
    w_nxt      = r_state;
    w_stall    = 1'b0;
    w_start    = 4'b0000;
    w_wb_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_nxt   = S_BUSY;
          w_stall = 1'b1;
          w_start = 4'b0001 << bus.mc_unit_i;
        end
      end
      S_BUSY: begin
        w_stall = 1'b1;
        if (w_done || w_timeout) w_nxt = S_WB;
      end
      S_WB: begin
        w_stall    = 1'b1;
        w_wb_valid = 1'b1;
        w_nxt      = S_IDLE;
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  // Op context, busy counter and held write-back tag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_unit    <= 2'd0;
      r_rd      <= 5'd0;
      r_cnt     <= '0;
      r_wb_unit <= 2'd0;
      r_wb_rd   <= 5'd0;
    end else begin
      if (w_accept) begin
        r_unit <= bus.mc_unit_i;
        r_rd   <= bus.mc_rd_i;
        r_cnt  <= '0;
      end else if (r_state == S_BUSY && r_cnt != '1) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (r_state == S_BUSY && w_nxt == S_WB) begin
        r_wb_unit <= r_unit;
        r_wb_rd   <= r_rd;
      end
    end
  end

  assign bus.unit_start_o    = w_start;
  assign bus.stall_general_o = w_stall;
  assign bus.wb_valid_o      = w_wb_valid;
  assign bus.wb_unit_o       = r_wb_unit;
  assign bus.wb_rd_o         = r_wb_rd;
  assign bus.busy_cnt_o      = r_cnt;

endmodule
